dcache: RTL and testbench
=========================

DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8: byte-free word address width.
REQ-002 SHALL have parameter DATA_BITS, default 16: data word width.
REQ-003 SHALL have parameter NUM_LINES, default 16: direct-mapped one-word lines; power of two, less than 2^ADDR_BITS.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: reset, synchronous, active-high.
- core_read_valid, in, 1: LSU read request.
- core_read_address, in, ADDR_BITS: read address.
- core_read_ready, out, 1: read response valid.
- core_read_data, out, DATA_BITS: read data.
- core_write_valid, in, 1: LSU write request.
- core_write_address, in, ADDR_BITS: write address.
- core_write_data, in, DATA_BITS: write data.
- core_write_ready, out, 1: write complete.
- flush, in, 1: invalidate all lines.
- mem_read_valid, out, 1: request to memory controller consumer port.
- mem_read_address, out, ADDR_BITS: controller read address.
- mem_read_ready, in, 1: controller read response.
- mem_read_data, in, DATA_BITS: controller read data.
- mem_write_valid, out, 1: controller write request.
- mem_write_address, out, ADDR_BITS: controller write address.
- mem_write_data, out, DATA_BITS: controller write data.
- mem_write_ready, in, 1: controller write done.

Function
REQ-005 SHALL use a four-phase handshake on both sides: valid is held until ready, then valid drops, then ready drops. The requester holds address and data stable while valid is high.
REQ-006 SHALL split each address into index = address[log2(NUM_LINES)-1:0] and tag = the remaining upper bits. Each line holds a valid bit, a tag and one data word.
REQ-007 SHALL implement the states IDLE, READ_MISS, WRITE_THRU and RELAY.
REQ-008 In IDLE, flush high SHALL clear every valid bit in that cycle. Flush takes precedence, and requests stall while flush is high. Flush outside IDLE SHALL be ignored until IDLE is reached.
REQ-009 In IDLE, if core_read_valid and core_write_valid are both high, the read SHALL be served first.
REQ-010 Read hit sampled in IDLE at cycle N: core_read_ready=1 with the line data at N+1, then go to RELAY. No memory traffic.
REQ-011 Read miss at cycle N: mem_read_valid=1 and mem_read_address set at N+1, then go to READ_MISS.
REQ-012 In READ_MISS, on the first cycle M with mem_read_ready=1, the block SHALL:
- fill the line (valid=1, tag, data);
- drive mem_read_valid=0;
- drive core_read_ready=1 and core_read_data=mem_read_data at M+1;
- go to RELAY.
REQ-013 A write SHALL be write-through, no-allocate:
- on a hit, update the line data in the IDLE cycle;
- on a miss, leave the array unchanged;
- in both cases drive mem_write_valid/address/data at N+1 and go to WRITE_THRU.
REQ-014 In WRITE_THRU, on mem_write_ready=1, the block SHALL drive mem_write_valid=0 and core_write_ready=1 at the next edge, then go to RELAY.
REQ-015 RELAY SHALL return to IDLE, dropping both core ready outputs, only in a cycle where all of these are low: the active core valid, mem_read_ready and mem_write_ready. No new memory request is issued before the controller releases.
REQ-016 Memory outputs SHALL be registered and SHALL stay stable while their valid is high.

Reset
REQ-017 On reset, the state SHALL be IDLE, all valid bits cleared, and every output 0, including mid-transaction. An in-flight memory request is abandoned, since the controller shares the reset.
REQ-018 Tag and data arrays need not be reset.

Configuration
REQ-019 With DCACHE_STATS_EN defined, the block SHALL add two outputs:
- hit_count, out, 16: reads that hit;
- miss_count, out, 16: reads that missed.
Each increments once per accepted read in IDLE, wraps at 0xFFFF->0, is cleared by reset, and is not cleared by flush.
REQ-020 Without DCACHE_STATS_EN, those ports and counters SHALL not exist, and behaviour is otherwise identical.

Structure
REQ-021 Package gpu_mem_pkg SHALL hold the dcache_state_t enum and the default ADDR_BITS/DATA_BITS constants.
REQ-022 Sub-module dcache_tag_store SHALL hold the valid/tag/data arrays. It provides a combinational lookup (hit, data), a single write port and a one-cycle flush.

Verification
REQ-023 Cold read of 0x23, with the controller answering 0xBEEF two cycles after request: mem_read_valid at N+1 with address 0x23; core_read_ready with 0xBEEF one cycle after mem_read_ready; miss_count=1.
REQ-024 Re-read 0x23: core_read_ready=1 with data 0xBEEF at N+1; mem_read_valid stays 0; hit_count=1.
REQ-025 Read 0x13 (same index 3, new tag), then read 0x23: both miss; the line is replaced each time; two memory reads are observed.
REQ-026 Write 0x23=0x1234 after a hit, then read 0x23: mem_write_valid with 0x23/0x1234; the read returns 0x1234 with no memory read.
REQ-027 Read and write valid in the same IDLE cycle, then flush, then read 0x23: the read is served first; after the flush the read misses.
REQ-028 Reset asserted during READ_MISS: next cycle all outputs are 0 and state is IDLE; a following read of 0x23 misses.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared types and default widths for the GPU memory path (data cache and friends).
package gpu_mem_pkg;

    localparam int DCACHE_ADDR_BITS = 8;
    localparam int DCACHE_DATA_BITS = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ_MISS,
        WRITE_THRU,
        RELAY
    } dcache_state_t;

endpackage

// File: rtl/dcache_tag_store.sv
// Direct-mapped valid/tag/data arrays for dcache: combinational lookup,
// one write port that also sets the line valid, and a single-cycle flush.
module dcache_tag_store #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int NUM_LINES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] lookup_address,
    output logic                 hit,
    output logic [DATA_BITS-1:0] lookup_data,
    input  logic                 write_en,
    input  logic [ADDR_BITS-1:0] write_address,
    input  logic [DATA_BITS-1:0] write_data,
    input  logic                 flush
);

    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_BITS-1:0]  tags  [NUM_LINES];
    logic [DATA_BITS-1:0] words [NUM_LINES];

    logic [IDX_BITS-1:0] lookup_index;
    logic [TAG_BITS-1:0] lookup_tag;
    logic [IDX_BITS-1:0] write_index;
    logic [TAG_BITS-1:0] write_tag;

    assign lookup_index = lookup_address[IDX_BITS-1:0];
    assign lookup_tag   = lookup_address[ADDR_BITS-1:IDX_BITS];
    assign write_index  = write_address[IDX_BITS-1:0];
    assign write_tag    = write_address[ADDR_BITS-1:IDX_BITS];

    assign hit         = valid[lookup_index] && (tags[lookup_index] == lookup_tag);
    assign lookup_data = words[lookup_index];

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid <= '0;
        end else if (write_en) begin
            valid[write_index] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays are left unreset; the cleared valid bits already mask them.
    always_ff @(posedge clk) begin
        if (write_en) begin
            tags[write_index]  <= write_tag;
            words[write_index] <= write_data;
        end
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-through, no-allocate data cache with four-phase handshakes.
// Define DCACHE_STATS_EN to add the hit_count/miss_count read statistics outputs.
module dcache
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS = DCACHE_ADDR_BITS,
    parameter int DATA_BITS = DCACHE_DATA_BITS,
    parameter int NUM_LINES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 core_read_valid,
    input  logic [ADDR_BITS-1:0] core_read_address,
    output logic                 core_read_ready,
    output logic [DATA_BITS-1:0] core_read_data,
    input  logic                 core_write_valid,
    input  logic [ADDR_BITS-1:0] core_write_address,
    input  logic [DATA_BITS-1:0] core_write_data,
    output logic                 core_write_ready,
    input  logic                 flush,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
`endif
);

    dcache_state_t state, state_next;
    logic          op_read, op_read_next;

    logic                 core_read_ready_next;
    logic [DATA_BITS-1:0] core_read_data_next;
    logic                 core_write_ready_next;
    logic                 mem_read_valid_next;
    logic [ADDR_BITS-1:0] mem_read_address_next;
    logic                 mem_write_valid_next;
    logic [ADDR_BITS-1:0] mem_write_address_next;
    logic [DATA_BITS-1:0] mem_write_data_next;

    logic [ADDR_BITS-1:0] lookup_address;
    logic                 hit;
    logic [DATA_BITS-1:0] lookup_data;
    logic                 store_write_en;
    logic [ADDR_BITS-1:0] store_write_address;
    logic [DATA_BITS-1:0] store_write_data;
    logic                 store_flush;
    logic                 active_valid;

    // Reads win the lookup port when both core requests are pending.
    assign lookup_address = core_read_valid ? core_read_address : core_write_address;
    assign active_valid   = op_read ? core_read_valid : core_write_valid;

    dcache_tag_store #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .NUM_LINES (NUM_LINES)
    ) u_tag_store (
        .clk            (clk),
        .reset          (reset),
        .lookup_address (lookup_address),
        .hit            (hit),
        .lookup_data    (lookup_data),
        .write_en       (store_write_en),
        .write_address  (store_write_address),
        .write_data     (store_write_data),
        .flush          (store_flush)
    );

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_next             = state;
        op_read_next           = op_read;
        core_read_ready_next   = core_read_ready;
        core_read_data_next    = core_read_data;
        core_write_ready_next  = core_write_ready;
        mem_read_valid_next    = mem_read_valid;
        mem_read_address_next  = mem_read_address;
        mem_write_valid_next   = mem_write_valid;
        mem_write_address_next = mem_write_address;
        mem_write_data_next    = mem_write_data;
        store_write_en         = 1'b0;
        store_write_address    = core_write_address;
        store_write_data       = core_write_data;
        store_flush            = 1'b0;

        case (state)
            IDLE: begin
                if (flush) begin
                    store_flush = 1'b1;
                end else if (core_read_valid) begin
                    op_read_next = 1'b1;
                    if (hit) begin
                        core_read_ready_next = 1'b1;
                        core_read_data_next  = lookup_data;
                        state_next           = RELAY;
                    end else begin
                        mem_read_valid_next   = 1'b1;
                        mem_read_address_next = core_read_address;
                        state_next            = READ_MISS;
                    end
                end else if (core_write_valid) begin
                    op_read_next           = 1'b0;
                    store_write_en         = hit;
                    mem_write_valid_next   = 1'b1;
                    mem_write_address_next = core_write_address;
                    mem_write_data_next    = core_write_data;
                    state_next             = WRITE_THRU;
                end
            end
            READ_MISS: begin
                if (mem_read_ready) begin
                    store_write_en       = 1'b1;
                    store_write_address  = mem_read_address;
                    store_write_data     = mem_read_data;
                    mem_read_valid_next  = 1'b0;
                    core_read_ready_next = 1'b1;
                    core_read_data_next  = mem_read_data;
                    state_next           = RELAY;
                end
            end
            WRITE_THRU: begin
                if (mem_write_ready) begin
                    mem_write_valid_next  = 1'b0;
                    core_write_ready_next = 1'b1;
                    state_next            = RELAY;
                end
            end
            RELAY: begin
                // Hold until both the core and the controller have finished their handshakes.
                if (!active_valid && !mem_read_ready && !mem_write_ready) begin
                    core_read_ready_next  = 1'b0;
                    core_write_ready_next = 1'b0;
                    state_next            = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            op_read           <= 1'b0;
            core_read_ready   <= 1'b0;
            core_read_data    <= '0;
            core_write_ready  <= 1'b0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
        end else begin
            state             <= state_next;
            op_read           <= op_read_next;
            core_read_ready   <= core_read_ready_next;
            core_read_data    <= core_read_data_next;
            core_write_ready  <= core_write_ready_next;
            mem_read_valid    <= mem_read_valid_next;
            mem_read_address  <= mem_read_address_next;
            mem_write_valid   <= mem_write_valid_next;
            mem_write_address <= mem_write_address_next;
            mem_write_data    <= mem_write_data_next;
        end
    end

`ifdef DCACHE_STATS_EN
    // Counted when a read is accepted in IDLE; flush leaves the totals alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && !flush && core_read_valid) begin
            if (hit) begin
                hit_count <= hit_count + 16'd1;
            end else begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`else
    // Statistics counters are absent in this build.
`endif

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: a behavioural memory controller answers the cache,
// expected read data and write-through traffic are queued when requests are driven.
module tb_dcache;

    logic        clk;
    logic        reset;
    logic        core_read_valid;
    logic [7:0]  core_read_address;
    logic        core_read_ready;
    logic [15:0] core_read_data;
    logic        core_write_valid;
    logic [7:0]  core_write_address;
    logic [15:0] core_write_data;
    logic        core_write_ready;
    logic        flush;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic        mem_write_valid;
    logic [7:0]  mem_write_address;
    logic [15:0] mem_write_data;
    logic        mem_write_ready;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] mem_model [256];
    logic [15:0] rd_q [$];
    logic [23:0] wr_q [$];
    int mem_reads      = 0;
    int rd_ready_cycle = 0;
    int rd_wait        = 0;
    int exp_hits       = 0;
    int exp_misses     = 0;

    dcache u_dut (
        .clk                (clk),
        .reset              (reset),
        .core_read_valid    (core_read_valid),
        .core_read_address  (core_read_address),
        .core_read_ready    (core_read_ready),
        .core_read_data     (core_read_data),
        .core_write_valid   (core_write_valid),
        .core_write_address (core_write_address),
        .core_write_data    (core_write_data),
        .core_write_ready   (core_write_ready),
        .flush              (flush),
        .mem_read_valid     (mem_read_valid),
        .mem_read_address   (mem_read_address),
        .mem_read_ready     (mem_read_ready),
        .mem_read_data      (mem_read_data),
        .mem_write_valid    (mem_write_valid),
        .mem_write_address  (mem_write_address),
        .mem_write_data     (mem_write_data),
        .mem_write_ready    (mem_write_ready)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count          (hit_count),
        .miss_count         (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory controller: reads answer on the second sampled cycle, writes at once.
    initial begin
        logic [23:0] wexp;
        mem_read_ready  = 1'b0;
        mem_read_data   = '0;
        mem_write_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mem_read_ready  = 1'b0;
                mem_write_ready = 1'b0;
                rd_wait         = 0;
            end else begin
                if (mem_read_valid && !mem_read_ready) begin
                    rd_wait++;
                    if (rd_wait == 2) begin
                        mem_read_data  = mem_model[mem_read_address];
                        mem_read_ready = 1'b1;
                        mem_reads++;
                        rd_ready_cycle = cyc;
                    end
                end else if (!mem_read_valid) begin
                    mem_read_ready = 1'b0;
                    rd_wait        = 0;
                end
                if (mem_write_valid && !mem_write_ready) begin
                    if (wr_q.size() == 0) begin
                        check("wr_unexpected", 32'd1, 32'd0);
                    end else begin
                        wexp = wr_q.pop_front();
                        check("wr_addr", mem_write_address, wexp[23:16]);
                        check("wr_data", mem_write_data, wexp[15:0]);
                    end
                    mem_model[mem_write_address] = mem_write_data;
                    mem_write_ready = 1'b1;
                end else if (!mem_write_valid) begin
                    mem_write_ready = 1'b0;
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_crr"}, core_read_ready, 0);
        check({tag, "_crd"}, core_read_data, 0);
        check({tag, "_cwr"}, core_write_ready, 0);
        check({tag, "_mrv"}, mem_read_valid, 0);
        check({tag, "_mra"}, mem_read_address, 0);
        check({tag, "_mwv"}, mem_write_valid, 0);
        check({tag, "_mwa"}, mem_write_address, 0);
        check({tag, "_mwd"}, mem_write_data, 0);
`ifdef DCACHE_STATS_EN
        check({tag, "_hits"}, hit_count, 0);
        check({tag, "_misses"}, miss_count, 0);
`endif
    endtask

    task automatic check_stats();
`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_misses);
`endif
    endtask

    task automatic read_req(input logic [7:0] addr, input bit exp_hit);
        core_read_address = addr;
        core_read_valid   = 1'b1;
        rd_q.push_back(mem_model[addr]);
        if (exp_hit) exp_hits++;
        else         exp_misses++;
    endtask

    task automatic read_finish(input logic [7:0] addr, input bit exp_hit);
        int base;
        logic [15:0] exp;
        base = mem_reads;
        @(negedge clk);
        if (exp_hit) begin
            check("hit_ready", core_read_ready, 1);
            check("hit_no_mem_read", mem_read_valid, 0);
            check("hit_no_mem_write", mem_write_valid, 0);
        end else begin
            check("miss_mem_valid", mem_read_valid, 1);
            check("miss_mem_addr", mem_read_address, addr);
            check("miss_not_ready", core_read_ready, 0);
        end
        for (int i = 0; i < 20 && !core_read_ready; i++) @(negedge clk);
        check("rd_ready", core_read_ready, 1);
        if (!exp_hit) check("miss_latency", cyc - rd_ready_cycle, 1);
        if (rd_q.size() == 0) begin
            check("rd_q_empty", 32'd1, 32'd0);
        end else begin
            exp = rd_q.pop_front();
            check("rd_data", core_read_data, exp);
        end
        core_read_valid = 1'b0;
        for (int i = 0; i < 20 && core_read_ready; i++) @(negedge clk);
        check("rd_release", core_read_ready, 0);
        check("mem_read_count", mem_reads - base, exp_hit ? 0 : 1);
    endtask

    task automatic do_read(input logic [7:0] addr, input bit exp_hit);
        read_req(addr, exp_hit);
        read_finish(addr, exp_hit);
    endtask

    task automatic write_req(input logic [7:0] addr, input logic [15:0] data);
        core_write_address = addr;
        core_write_data    = data;
        core_write_valid   = 1'b1;
        wr_q.push_back({addr, data});
    endtask

    task automatic write_finish(input logic [7:0] addr, input logic [15:0] data);
        @(negedge clk);
        check("wt_valid", mem_write_valid, 1);
        check("wt_addr", mem_write_address, addr);
        check("wt_data", mem_write_data, data);
        check("wt_not_ready", core_write_ready, 0);
        for (int i = 0; i < 20 && !core_write_ready; i++) @(negedge clk);
        check("wr_ready", core_write_ready, 1);
        core_write_valid = 1'b0;
        for (int i = 0; i < 20 && core_write_ready; i++) @(negedge clk);
        check("wr_release", core_write_ready, 0);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [15:0] data);
        write_req(addr, data);
        write_finish(addr, data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 16'h1000 + 16'(i);
        mem_model[8'h23] = 16'hBEEF;
        mem_model[8'h13] = 16'hCAFE;
        reset              = 1'b1;
        core_read_valid    = 1'b0;
        core_read_address  = '0;
        core_write_valid   = 1'b0;
        core_write_address = '0;
        core_write_data    = '0;
        flush              = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;

        // Cold miss, then hit on the same address.
        do_read(8'h23, 1'b0);
        check_stats();
        do_read(8'h23, 1'b1);
        check_stats();

        // Same index, different tag: each read replaces the line.
        do_read(8'h13, 1'b0);
        do_read(8'h23, 1'b0);
        check_stats();

        // Write hit updates the line; write miss leaves the array alone.
        do_read(8'h23, 1'b1);
        do_write(8'h23, 16'h1234);
        do_read(8'h23, 1'b1);
        do_write(8'h45, 16'h7777);
        do_read(8'h45, 1'b0);
        check_stats();

        // Simultaneous read and write: the read goes first, then the write.
        read_req(8'h23, 1'b1);
        write_req(8'h23, 16'h4321);
        read_finish(8'h23, 1'b1);
        write_finish(8'h23, 16'h4321);

        // Flush stalls a pending read, then the read misses.
        flush = 1'b1;
        read_req(8'h23, 1'b0);
        @(negedge clk);
        check("flush_stall_rd", core_read_ready, 0);
        check("flush_stall_mem", mem_read_valid, 0);
        flush = 1'b0;
        read_finish(8'h23, 1'b0);
        check_stats();

        // Reset in the middle of a miss abandons it.
        read_req(8'h33, 1'b0);
        @(negedge clk);
        check("pre_reset_miss", mem_read_valid, 1);
        reset           = 1'b1;
        core_read_valid = 1'b0;
        if (rd_q.size() > 0) void'(rd_q.pop_back());
        @(negedge clk);
        check_outputs_zero("mid_reset");
        reset      = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        do_read(8'h23, 1'b0);
        check_stats();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
